prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Host-side loader and run controller for the pipelined CPU datapath.
//  - Consumes a byte stream (from the UART receiver) using a valid/ready handshake.
//  - Assembles bytes into instruction words and writes them into instruction memory
//    through the user write port (user_inst_write / user_inst_addr / user_inst_wen).
//  - Drives the datapath run controls ap_start, ap_stop and resume.
//  - Is the write/control end of the datapath's program-load and halt/resume interface.
// PARAMETERS
//  DWIDTH   16         instruction/data word width; multiple of 8
//  AWIDTH   8          instruction memory address width
//  TIMEOUT  1_000_000  idle cycles allowed between bytes of a load before it aborts
// PORTS
//  clk              in   1       system clock
//  rst              in   1       asynchronous active-high reset
//  rx_data          in   8       received byte
//  rx_valid         in   1       rx_data valid
//  rx_ready         out  1       loader accepts a byte; transfer occurs when rx_valid && rx_ready
//  halt             in   1       datapath halted on a halt instruction
//  user_inst_write  out  DWIDTH  instruction word to write
//  user_inst_addr   out  AWIDTH  instruction memory write address
//  user_inst_wen    out  1       one-cycle write strobe
//  ap_start         out  1       one-cycle pulse: start execution
//  ap_stop          out  1       one-cycle pulse: stop execution
//  resume           out  1       one-cycle pulse: leave halt
//  busy             out  1       high in any state other than IDLE
//  load_err         out  1       sticky; last load aborted
//  words_loaded     out  AWIDTH+1  number of words written by the last/current load
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE.
//   - Every output is 0, except rx_ready, which is 1 (IDLE).
//   - All outputs except rx_ready and busy are registered.
//   - Reset asserted mid-load abandons the load immediately. No further wen. load_err=0.
//  Commands accepted in IDLE:
//   - 0xA5 LOAD:
//     - Pulse ap_stop the next cycle.
//     - Clear load_err and words_loaded.
//     - Go to COUNT.
//   - 0x53 STOP: pulse ap_stop the next cycle. Stay in IDLE.
//   - 0x52 RESUME: pulse resume the next cycle if halt==1. Ignored if halt==0.
//   - Any other byte: consumed and ignored.
//  COUNT:
//   - The next byte is N, the number of words.
//   - N==0: go to IDLE. No writes, no ap_start, load_err stays 0.
//   - N > 2**AWIDTH: set load_err and go to IDLE.
//   - Otherwise: latch N, set word index=0, byte index=0, go to DATA.
//  DATA:
//   - Accept DWIDTH/8 bytes, MSB first, shifting them into the word register.
//   - After the last byte of the word is accepted, go to WRITE.
//  WRITE (exactly 1 cycle, rx_ready=0):
//   - Drive user_inst_wen=1, user_inst_addr=word index, user_inst_write=assembled word.
//   - Increment words_loaded.
//   - If word index==N-1, go to START. Otherwise increment word index and go to DATA.
//  START (1 cycle, rx_ready=0): pulse ap_start, then go to IDLE.
//  Latency: last byte accepted at cycle t -> wen high at t+1 -> ap_start high at t+2.
//  Address and data are stable for the whole cycle in which wen is high. wen is 0 otherwise.
//  Timeout:
//   - The counter clears on every accepted byte and on entering COUNT.
//   - It counts while in COUNT or DATA.
//   - When it reaches TIMEOUT: go to IDLE and set load_err. No ap_start.
//   - Words already written stay written.
//  rx_ready: 1 in IDLE, COUNT and DATA; 0 in WRITE and START.
//  ap_stop, ap_start and resume are never high together. Each is high for exactly 1 cycle per event.
//  halt is sampled only when a RESUME byte is accepted. halt may change at any time.
// TESTING
//  1) Reset, then stream A5 02 12 34 AB CD (one byte per cycle)
//     -> ap_stop pulse once
//     -> wen@addr0=0x1234, then wen@addr1=0xABCD
//     -> ap_start pulse 1 cycle after the second wen
//     -> words_loaded=2, busy falls afterwards.
//  2) With halt=1, send 0x52 -> resume high exactly 1 cycle.
//     With halt=0, send 0x52 -> no pulse.
//  3) Send A5 01 12, then stall rx_valid for TIMEOUT cycles
//     -> load_err=1, state IDLE, no wen, no ap_start.
//     Next A5 clears load_err.
//  4) Send A5 00 -> ap_stop pulse only. No wen, no ap_start. load_err=0.
//  5) Hold rx_valid=1 continuously with back-to-back bytes
//     -> rx_ready drops during WRITE/START; no byte is lost or duplicated
//     (compare memory contents against a model).
//  6) Assert rst between the two words of test 1
//     -> all outputs go to their reset values immediately; no further wen;
//     a subsequent full load completes normally.

Source files
------------

// File: rtl/prog_loader.sv
// Host-side program loader: assembles a byte stream into instruction words, writes
// them into instruction memory and drives the datapath start/stop/resume pulses.
module prog_loader #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              halt,
  output logic [DWIDTH-1:0] user_inst_write,
  output logic [AWIDTH-1:0] user_inst_addr,
  output logic              user_inst_wen,
  output logic              ap_start,
  output logic              ap_stop,
  output logic              resume,
  output logic              busy,
  output logic              load_err,
  output logic [AWIDTH:0]   words_loaded
);

  localparam int BYTES = DWIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CMD_LOAD   = 8'hA5;
  localparam logic [7:0] CMD_STOP   = 8'h53;
  localparam logic [7:0] CMD_RESUME = 8'h52;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_START} state_t;

  state_t            state_r, state_s;
  logic [DWIDTH-1:0] word_r, shift_s, wdata_r;
  logic [AWIDTH-1:0] word_idx_r, addr_r;
  logic [BW-1:0]     byte_idx_r;
  logic [AWIDTH:0]   n_r, words_loaded_r;
  logic [TW-1:0]     tmo_r;
  logic              wen_r, start_r, stop_r, resume_r, load_err_r;
  logic              accept_s, timeout_s, last_byte_s, last_word_s, n_big_s;

  assign user_inst_write = wdata_r;
  assign user_inst_addr  = addr_r;
  assign user_inst_wen   = wen_r;
  assign ap_start        = start_r;
  assign ap_stop         = stop_r;
  assign resume          = resume_r;
  assign load_err        = load_err_r;
  assign words_loaded    = words_loaded_r;

  // Handshake, status and shared decode terms derived from the current state.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b1;
    case (state_r)
      S_IDLE: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
      end
      S_COUNT, S_DATA: rx_ready = 1'b1;
      default:         rx_ready = 1'b0;
    endcase
    accept_s    = rx_valid && rx_ready;
    timeout_s   = (tmo_r == TW'(TIMEOUT));
    last_byte_s = (byte_idx_r == BW'(BYTES - 1));
    last_word_s = ({1'b0, word_idx_r} == (n_r - (AWIDTH + 1)'(1)));
    n_big_s     = (32'(rx_data) > (32'd1 << AWIDTH));
    // MSB-first assembly: the newest byte lands in the low byte lane.
    shift_s     = DWIDTH'({word_r, rx_data});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; an arriving byte takes priority over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && (rx_data == CMD_LOAD)) state_s = S_COUNT;
        else                                   state_s = S_IDLE;
      end
      S_COUNT: begin
        if (accept_s) begin
          if ((rx_data == 8'd0) || n_big_s) state_s = S_IDLE;
          else                              state_s = S_DATA;
        end else if (timeout_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_COUNT;
        end
      end
      S_DATA: begin
        if (accept_s && last_byte_s) state_s = S_WRITE;
        else if (accept_s)           state_s = S_DATA;
        else if (timeout_s)          state_s = S_IDLE;
        else                         state_s = S_DATA;
      end
      S_WRITE: begin
        if (last_word_s) state_s = S_START;
        else             state_s = S_DATA;
      end
      S_START: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath, registered pulses and status; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r         <= '0;
      wdata_r        <= '0;
      word_idx_r     <= '0;
      addr_r         <= '0;
      byte_idx_r     <= '0;
      n_r            <= '0;
      words_loaded_r <= '0;
      tmo_r          <= '0;
      wen_r          <= 1'b0;
      start_r        <= 1'b0;
      stop_r         <= 1'b0;
      resume_r       <= 1'b0;
      load_err_r     <= 1'b0;
    end else begin
      wen_r    <= 1'b0;
      start_r  <= 1'b0;
      stop_r   <= 1'b0;
      resume_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            case (rx_data)
              CMD_LOAD: begin
                stop_r         <= 1'b1;
                load_err_r     <= 1'b0;
                words_loaded_r <= '0;
                tmo_r          <= '0;
              end
              CMD_STOP:   stop_r   <= 1'b1;
              CMD_RESUME: resume_r <= halt;
              default:    stop_r   <= 1'b0;
            endcase
          end
        end
        S_COUNT: begin
          if (accept_s) begin
            tmo_r <= '0;
            if (rx_data == 8'd0) begin
              load_err_r <= 1'b0;
            end else if (n_big_s) begin
              load_err_r <= 1'b1;
            end else begin
              n_r        <= (AWIDTH + 1)'(rx_data);
              word_idx_r <= '0;
              byte_idx_r <= '0;
            end
          end else if (timeout_s) begin
            load_err_r <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        S_DATA: begin
          if (accept_s) begin
            tmo_r  <= '0;
            word_r <= shift_s;
            if (last_byte_s) begin
              byte_idx_r     <= '0;
              wen_r          <= 1'b1;
              addr_r         <= word_idx_r;
              wdata_r        <= shift_s;
              words_loaded_r <= words_loaded_r + (AWIDTH + 1)'(1);
            end else begin
              byte_idx_r <= byte_idx_r + BW'(1);
            end
          end else if (timeout_s) begin
            load_err_r <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        S_WRITE: begin
          if (last_word_s) start_r    <= 1'b1;
          else             word_idx_r <= word_idx_r + AWIDTH'(1);
        end
        default: start_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: load, commands, timeout, empty load,
// back-to-back streaming and reset in the middle of a load.
module tb_prog_loader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          halt = 1'b0;
  logic [DW-1:0] user_inst_write;
  logic [AW-1:0] user_inst_addr;
  logic          user_inst_wen;
  logic          ap_start, ap_stop, resume, busy, load_err;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_wen = 0, n_start = 0, n_stop = 0, n_resume = 0, n_stall = 0;
  int wen_cyc = 0, start_cyc = 0, acc_cyc = 0;
  logic overlap = 1'b0;
  logic [AW+DW-1:0] wlog[$];
  logic [7:0] txq[$];

  prog_loader #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt(halt), .user_inst_write(user_inst_write), .user_inst_addr(user_inst_addr),
    .user_inst_wen(user_inst_wen), .ap_start(ap_start), .ap_stop(ap_stop), .resume(resume),
    .busy(busy), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (user_inst_wen) begin
      n_wen   <= n_wen + 1;
      wen_cyc <= cyc;
      wlog.push_back({user_inst_addr, user_inst_write});
    end
    if (ap_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
    end
    if (ap_stop)  n_stop   <= n_stop + 1;
    if (resume)   n_resume <= n_resume + 1;
    if (rx_valid && rx_ready)  acc_cyc <= cyc;
    if (rx_valid && !rx_ready) n_stall <= n_stall + 1;
    if ((int'(ap_start) + int'(ap_stop) + int'(resume)) > 1) overlap <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_stream();
    for (int i = 0; i < txq.size(); i++) begin
      int w = 0;
      rx_data  = txq[i];
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      total++;
      if (!rx_ready) begin
        bad++;
        $display("FAIL send_accept: byte %0d rx_ready=%b want 1", i, rx_ready);
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%b want 0", busy); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (user_inst_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", user_inst_wen); end
    total++; if ({ap_start, ap_stop, resume} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {ap_start, ap_stop, resume}); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    total++; if ({user_inst_addr, user_inst_write} !== 24'h0) begin bad++; $display("FAIL reset_addr_data: got %h want 0", {user_inst_addr, user_inst_write}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    int s_wen = n_wen, s_stop = n_stop, s_start = n_start, s_log = wlog.size();
    txq = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stream();
    wait_idle();
    total++; if (n_stop - s_stop !== 1) begin bad++; $display("FAIL load_stop: got %0d pulses want 1", n_stop - s_stop); end
    total++; if (n_wen - s_wen !== 2) begin bad++; $display("FAIL load_wen_count: got %0d want 2", n_wen - s_wen); end
    total++; if (wlog[s_log] !== {8'h00, 16'h1234}) begin bad++; $display("FAIL load_word0: got %h want 001234", wlog[s_log]); end
    total++; if (wlog[s_log+1] !== {8'h01, 16'hABCD}) begin bad++; $display("FAIL load_word1: got %h want 01abcd", wlog[s_log+1]); end
    total++; if (n_start - s_start !== 1) begin bad++; $display("FAIL load_start: got %0d pulses want 1", n_start - s_start); end
    total++; if (wen_cyc !== acc_cyc + 1) begin bad++; $display("FAIL load_wen_latency: got %0d want %0d", wen_cyc, acc_cyc + 1); end
    total++; if (start_cyc !== wen_cyc + 1) begin bad++; $display("FAIL load_start_latency: got %0d want %0d", start_cyc, wen_cyc + 1); end
    total++; if (words_loaded !== 9'd2) begin bad++; $display("FAIL load_words: got %0d want 2", words_loaded); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL load_err_clear: got %b want 0", load_err); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL load_overlap: got %b want 0", overlap); end
  endtask

  task automatic test_commands();
    int s_res = n_resume, s_stop = n_stop;
    halt = 1'b1;
    txq = {8'h52};
    send_stream();
    halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_resume - s_res !== 1) begin bad++; $display("FAIL resume_halted: got %0d pulses want 1", n_resume - s_res); end
    send_stream();
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_resume - s_res !== 1) begin bad++; $display("FAIL resume_not_halted: got %0d pulses want 1", n_resume - s_res); end
    txq = {8'h53};
    send_stream();
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_stop - s_stop !== 1) begin bad++; $display("FAIL stop_cmd: got %0d pulses want 1", n_stop - s_stop); end
    txq = {8'h7E};
    send_stream();
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL other_byte_busy: got %b want 0", busy); end
    total++; if ((n_stop - s_stop) + (n_resume - s_res) !== 2) begin bad++; $display("FAIL other_byte_pulses: got %0d want 2", (n_stop - s_stop) + (n_resume - s_res)); end
  endtask

  task automatic test_timeout();
    int s_wen = n_wen, s_start = n_start;
    txq = {8'hA5, 8'h01, 8'h12};
    send_stream();
    repeat (TO / 2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early_busy: got %b want 1", busy); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL timeout_early_err: got %b want 0", load_err); end
    repeat (TO + 5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", load_err); end
    total++; if (n_wen - s_wen !== 0) begin bad++; $display("FAIL timeout_wen: got %0d want 0", n_wen - s_wen); end
    total++; if (n_start - s_start !== 0) begin bad++; $display("FAIL timeout_start: got %0d want 0", n_start - s_start); end
    txq = {8'hA5};
    send_stream();
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL timeout_err_cleared: got %b want 0", load_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_reload_busy: got %b want 1", busy); end
    txq = {8'h00};
    send_stream();
    wait_idle();
  endtask

  task automatic test_zero_words();
    int s_wen = n_wen, s_stop = n_stop, s_start = n_start;
    txq = {8'hA5, 8'h00};
    send_stream();
    wait_idle();
    total++; if (n_stop - s_stop !== 1) begin bad++; $display("FAIL zero_stop: got %0d want 1", n_stop - s_stop); end
    total++; if (n_wen - s_wen !== 0) begin bad++; $display("FAIL zero_wen: got %0d want 0", n_wen - s_wen); end
    total++; if (n_start - s_start !== 0) begin bad++; $display("FAIL zero_start: got %0d want 0", n_start - s_start); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL zero_err: got %b want 0", load_err); end
    total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL zero_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_back_to_back();
    int s_stall = n_stall, s_start = n_start, s_stop = n_stop, s_log = wlog.size();
    logic [AW+DW-1:0] exp_log[4];
    exp_log[0] = {8'h00, 16'h0102};
    exp_log[1] = {8'h01, 16'h0304};
    exp_log[2] = {8'h02, 16'h0506};
    exp_log[3] = {8'h00, 16'hBEEF};
    txq = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA5, 8'h01, 8'hBE, 8'hEF};
    send_stream();
    wait_idle();
    total++; if (wlog.size() - s_log !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", wlog.size() - s_log); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[s_log+i] !== exp_log[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, wlog[s_log+i], exp_log[i]); end
    end
    total++; if (n_stall - s_stall !== 4) begin bad++; $display("FAIL b2b_stalls: got %0d want 4", n_stall - s_stall); end
    total++; if (n_start - s_start !== 2) begin bad++; $display("FAIL b2b_start: got %0d want 2", n_start - s_start); end
    total++; if (n_stop - s_stop !== 2) begin bad++; $display("FAIL b2b_stop: got %0d want 2", n_stop - s_stop); end
    total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL b2b_words: got %0d want 1", words_loaded); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_overlap: got %b want 0", overlap); end
  endtask

  task automatic test_reset_midload();
    int s_wen, s_start, s_log;
    txq = {8'hA5, 8'h02, 8'h12, 8'h34};
    send_stream();
    @(posedge clk);
    #1;
    total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL mid_words_before: got %0d want 1", words_loaded); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL mid_rx_ready: got %b want 1", rx_ready); end
    total++; if (user_inst_wen !== 1'b0) begin bad++; $display("FAIL mid_wen: got %b want 0", user_inst_wen); end
    total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL mid_words: got %0d want 0", words_loaded); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", load_err); end
    s_wen = n_wen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    txq = {8'hAB, 8'hCD};
    send_stream();
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_wen - s_wen !== 0) begin bad++; $display("FAIL mid_no_wen: got %0d want 0", n_wen - s_wen); end
    s_start = n_start;
    s_log   = wlog.size();
    txq = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream();
    wait_idle();
    total++; if (wlog[s_log] !== {8'h00, 16'h1122}) begin bad++; $display("FAIL mid_reload0: got %h want 001122", wlog[s_log]); end
    total++; if (wlog[s_log+1] !== {8'h01, 16'h3344}) begin bad++; $display("FAIL mid_reload1: got %h want 013344", wlog[s_log+1]); end
    total++; if (n_start - s_start !== 1) begin bad++; $display("FAIL mid_reload_start: got %0d want 1", n_start - s_start); end
    total++; if (words_loaded !== 9'd2) begin bad++; $display("FAIL mid_reload_words: got %0d want 2", words_loaded); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_commands();
    test_timeout();
    test_zero_words();
    test_back_to_back();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
